// File: rtl/phase_a_pkg.sv
// Shared types and default sizing for the phase_a iteration sequencer.
package phase_a_pkg;

    localparam int unsigned SIZE_DEF      = 3072;
    localparam int unsigned RADIX_DEF     = 72;
    localparam int unsigned SIZE_LOG_DEF  = 6;
    localparam int unsigned NUM_WORDS_DEF = 43;
    localparam int unsigned TIMEOUT_DEF   = 63;

    localparam int unsigned A_W   = SIZE_DEF + RADIX_DEF + SIZE_LOG_DEF;
    localparam int unsigned CNT_W = $clog2(NUM_WORDS_DEF + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WORD,
        ISSUE,
        WAIT_RESP,
        DONE
    } state_t;

endpackage

// File: rtl/phase_a_sequencer.sv
// Feeds NUM_WORDS operands to phase_a one at a time and returns the final accumulator.
// Optional response watchdog: define PHASE_A_WATCHDOG_EN.
module phase_a_sequencer
    import phase_a_pkg::*;
#(
    parameter int unsigned Size      = SIZE_DEF,
    parameter int unsigned radix     = RADIX_DEF,
    parameter int unsigned Size_log  = SIZE_LOG_DEF,
    parameter int unsigned NUM_WORDS = NUM_WORDS_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [Size-1:0]               acc_init,
    input  logic                          word_valid,
    input  logic [radix-1:0]              word_data,
    input  logic [Size_log-1:0]           word_ext,
    output logic                          word_ready,
    output logic [Size+radix+Size_log-1:0] pa_a,
    output logic                          pa_en,
    output logic                          pa_if_last,
    input  logic [Size-1:0]               pa_new_a,
    input  logic                          pa_en_out,
    output logic                          busy,
    output logic                          res_valid,
    output logic [Size-1:0]               res_data,
    output logic                          err
);

    localparam int unsigned CW = $clog2(NUM_WORDS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_WORDS - 1);

    if (NUM_WORDS < 1 || TIMEOUT < 1 || TIMEOUT > 256) begin : g_cfg_check
        $error("phase_a_sequencer: NUM_WORDS must be >= 1 and TIMEOUT in 1..256");
    end

    state_t              state, state_next;
    logic [Size-1:0]     acc;
    logic [CW-1:0]       cnt;
    logic                handshake;
    logic                timeout;
    logic                is_last;
    logic [Size_log-1:0] ext_sel;

    assign handshake = word_valid && word_ready;
    assign is_last   = (cnt == LAST_CNT);
    assign ext_sel   = is_last ? word_ext : '0;

`ifdef PHASE_A_WATCHDOG_EN
    logic [7:0] wd_timer;

    always_ff @(posedge clk) begin
        if (!rst_n || state != WAIT_RESP) begin
            wd_timer <= '0;
        end else begin
            wd_timer <= wd_timer + 8'd1;
        end
    end

    // Fires on the TIMEOUT-th cycle spent in WAIT_RESP.
    assign timeout = (state == WAIT_RESP) && (wd_timer == 8'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (start) state_next = WAIT_WORD;
            WAIT_WORD: if (handshake) state_next = ISSUE;
            ISSUE:     state_next = WAIT_RESP;
            WAIT_RESP: begin
                if (pa_en_out) begin
                    state_next = pa_if_last ? DONE : WAIT_WORD;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        word_ready = (state == WAIT_WORD);
        pa_en      = (state == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            pa_a       <= '0;
            pa_if_last <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            err        <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= acc_init;
                        cnt  <= '0;
                        err  <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                WAIT_WORD: begin
                    if (handshake) begin
                        pa_a       <= {ext_sel, word_data, acc};
                        pa_if_last <= is_last;
                    end
                end
                WAIT_RESP: begin
                    if (pa_en_out) begin
                        acc <= pa_new_a;
                        cnt <= cnt + 1'b1;
                    end else if (timeout) begin
                        err  <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                DONE: begin
                    res_data  <= acc;
                    res_valid <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
            // A completion pulse with nothing in flight is dropped but flagged.
            if (pa_en_out && state != WAIT_RESP) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phase_a_sequencer.sv
// Directed bench for phase_a_sequencer (NUM_WORDS=3 main DUT, NUM_WORDS=1 boundary DUT).
// Watchdog scenario runs only when PHASE_A_WATCHDOG_EN is defined.
module tb_phase_a_sequencer;

    localparam int unsigned SZ  = 64;
    localparam int unsigned RX  = 72;
    localparam int unsigned SL  = 6;
    localparam int unsigned AW  = SZ + RX + SL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          start = 1'b0;
    logic [SZ-1:0] acc_init = '0;
    logic          word_valid = 1'b0;
    logic [RX-1:0] word_data = '0;
    logic [SL-1:0] word_ext = '0;
    logic          word_ready;
    logic [AW-1:0] pa_a;
    logic          pa_en;
    logic          pa_if_last;
    logic [SZ-1:0] pa_new_a = '0;
    logic          pa_en_out = 1'b0;
    logic          busy;
    logic          res_valid;
    logic [SZ-1:0] res_data;
    logic          err;

    logic          start1 = 1'b0;
    logic [SZ-1:0] acc_init1 = '0;
    logic          word_valid1 = 1'b0;
    logic [RX-1:0] word_data1 = '0;
    logic [SL-1:0] word_ext1 = '0;
    logic          word_ready1;
    logic [AW-1:0] pa_a1;
    logic          pa_en1;
    logic          pa_if_last1;
    logic [SZ-1:0] pa_new_a1 = '0;
    logic          pa_en_out1 = 1'b0;
    logic          busy1;
    logic          res_valid1;
    logic [SZ-1:0] res_data1;
    logic          err1;

    int n_checks = 0;
    int n_fail   = 0;
    int pa_en_count = 0;
    int last_count  = 0;
    int res_count   = 0;

    phase_a_sequencer #(
        .Size(SZ), .radix(RX), .Size_log(SL), .NUM_WORDS(3), .TIMEOUT(63)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_init(acc_init),
        .word_valid(word_valid), .word_data(word_data), .word_ext(word_ext),
        .word_ready(word_ready), .pa_a(pa_a), .pa_en(pa_en), .pa_if_last(pa_if_last),
        .pa_new_a(pa_new_a), .pa_en_out(pa_en_out), .busy(busy),
        .res_valid(res_valid), .res_data(res_data), .err(err)
    );

    phase_a_sequencer #(
        .Size(SZ), .radix(RX), .Size_log(SL), .NUM_WORDS(1), .TIMEOUT(63)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .acc_init(acc_init1),
        .word_valid(word_valid1), .word_data(word_data1), .word_ext(word_ext1),
        .word_ready(word_ready1), .pa_a(pa_a1), .pa_en(pa_en1), .pa_if_last(pa_if_last1),
        .pa_new_a(pa_new_a1), .pa_en_out(pa_en_out1), .busy(busy1),
        .res_valid(res_valid1), .res_data(res_data1), .err(err1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pa_en) begin
            pa_en_count++;
            if (pa_if_last) last_count++;
        end
        if (res_valid) res_count++;
    end

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_word_ready"}, 192'(word_ready), 0);
        check_eq({tag, "_pa_a"},       192'(pa_a), 0);
        check_eq({tag, "_pa_en"},      192'(pa_en), 0);
        check_eq({tag, "_pa_if_last"}, 192'(pa_if_last), 0);
        check_eq({tag, "_busy"},       192'(busy), 0);
        check_eq({tag, "_res_valid"},  192'(res_valid), 0);
        check_eq({tag, "_res_data"},   192'(res_data), 0);
        check_eq({tag, "_err"},        192'(err), 0);
    endtask

    // Presents one word, waits (bounded) for the handshake edge; returns in the ISSUE cycle.
    task automatic send_word(input logic [RX-1:0] data, input logic [SL-1:0] ext);
        int n = 0;
        word_valid = 1'b1;
        word_data  = data;
        word_ext   = ext;
        while (!word_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("word_ready_wait", 192'(word_ready), 1);
        tick();
        word_valid = 1'b0;
        check_eq("pa_en_issue", 192'(pa_en), 1);
    endtask

    // Stub phase_a: answers a[Size-1:0]+1 after the given number of idle cycles.
    task automatic respond(input int wait_cycles);
        repeat (wait_cycles) tick();
        check_eq("pa_en_quiet", 192'(pa_en), 0);
        pa_new_a  = pa_a[SZ-1:0] + 64'd1;
        pa_en_out = 1'b1;
        tick();
        pa_en_out = 1'b0;
    endtask

    initial begin
        int base_pa;
        int base_last;
        int base_res;

        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;

        // Run 1: acc_init=5, three words, expect 8.
        start = 1'b1;
        acc_init = 64'h5;
        tick();
        start = 1'b0;
        check_eq("busy_after_start", 192'(busy), 1);
        base_pa = pa_en_count;
        base_last = last_count;
        base_res = res_count;
        repeat (10) tick();
        check_eq("idle_word_ready", 192'(word_ready), 1);
        check_eq("idle_no_pa_en", 192'(pa_en_count - base_pa), 0);

        send_word(72'hAA, 6'h15);
        check_eq("w0_top", 192'(pa_a[AW-1-:SL]), 0);
        check_eq("w0_data", 192'(pa_a[SZ+:RX]), 192'h0AA);
        check_eq("w0_acc", 192'(pa_a[SZ-1:0]), 5);
        check_eq("w0_last", 192'(pa_if_last), 0);
        respond(16);

        send_word(72'h1234, 6'h3F);
        check_eq("w1_top", 192'(pa_a[AW-1-:SL]), 0);
        check_eq("w1_acc", 192'(pa_a[SZ-1:0]), 6);
        check_eq("w1_last", 192'(pa_if_last), 0);
        tick();
        start = 1'b1;
        acc_init = 64'hFFFF;
        tick();
        start = 1'b0;
        check_eq("start_ignored_busy", 192'(busy), 1);
        check_eq("start_ignored_ready", 192'(word_ready), 0);
        respond(14);

        send_word(72'h1, 6'h2A);
        check_eq("w2_top", 192'(pa_a[AW-1-:SL]), 192'h2A);
        check_eq("w2_data", 192'(pa_a[SZ+:RX]), 1);
        check_eq("w2_acc", 192'(pa_a[SZ-1:0]), 7);
        check_eq("w2_last", 192'(pa_if_last), 1);
        respond(16);
        check_eq("done_no_res_yet", 192'(res_valid), 0);
        tick();
        check_eq("res_valid", 192'(res_valid), 1);
        check_eq("res_data", 192'(res_data), 8);
        check_eq("busy_drop", 192'(busy), 0);
        tick();
        check_eq("res_valid_pulse", 192'(res_valid), 0);
        check_eq("res_data_hold", 192'(res_data), 8);
        check_eq("pa_en_pulses", 192'(pa_en_count - base_pa), 3);
        check_eq("last_pulses", 192'(last_count - base_last), 1);
        check_eq("res_pulses", 192'(res_count - base_res), 1);

        // Run 2: spurious completion in WAIT_WORD, then a clean finish from 0x10.
        start = 1'b1;
        acc_init = 64'h10;
        tick();
        start = 1'b0;
        pa_new_a = 64'hDEAD;
        pa_en_out = 1'b1;
        tick();
        pa_en_out = 1'b0;
        check_eq("spur_err", 192'(err), 1);
        check_eq("spur_ready", 192'(word_ready), 1);
        check_eq("spur_busy", 192'(busy), 1);
        send_word(72'h5, 6'h0);
        check_eq("spur_acc_kept", 192'(pa_a[SZ-1:0]), 192'h10);
        respond(16);
        send_word(72'h6, 6'h0);
        respond(16);
        send_word(72'h7, 6'h01);
        check_eq("r2_top", 192'(pa_a[AW-1-:SL]), 1);
        respond(16);
        tick();
        check_eq("r2_res", 192'(res_data), 192'h13);
        check_eq("r2_err_sticky", 192'(err), 1);

        // Run 3: start clears err; reset pulse while waiting on phase_a.
        tick();
        start = 1'b1;
        acc_init = 64'h40;
        tick();
        start = 1'b0;
        check_eq("start_clears_err", 192'(err), 0);
        send_word(72'h9, 6'h0);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("midreset");
        tick();
        check_eq("midreset_idle_ready", 192'(word_ready), 0);
        check_eq("midreset_idle_busy", 192'(busy), 0);

`ifdef PHASE_A_WATCHDOG_EN
        start = 1'b1;
        acc_init = 64'h3;
        tick();
        start = 1'b0;
        send_word(72'h2, 6'h0);
        repeat (63) tick();
        check_eq("wd_not_yet", 192'(err), 0);
        tick();
        check_eq("wd_err", 192'(err), 1);
        check_eq("wd_busy", 192'(busy), 0);
        check_eq("wd_no_res", 192'(res_valid), 0);
        tick();
        check_eq("wd_idle", 192'(word_ready), 0);
`endif

        // Single-word configuration: the first pulse is already the last.
        start1 = 1'b1;
        acc_init1 = 64'h20;
        tick();
        start1 = 1'b0;
        check_eq("n1_ready", 192'(word_ready1), 1);
        word_valid1 = 1'b1;
        word_data1 = 72'h3;
        word_ext1 = 6'h11;
        tick();
        word_valid1 = 1'b0;
        check_eq("n1_pa_en", 192'(pa_en1), 1);
        check_eq("n1_last", 192'(pa_if_last1), 1);
        check_eq("n1_top", 192'(pa_a1[AW-1-:SL]), 192'h11);
        check_eq("n1_acc", 192'(pa_a1[SZ-1:0]), 192'h20);
        repeat (16) tick();
        pa_new_a1 = 64'h99;
        pa_en_out1 = 1'b1;
        tick();
        pa_en_out1 = 1'b0;
        tick();
        check_eq("n1_res_valid", 192'(res_valid1), 1);
        check_eq("n1_res_data", 192'(res_data1), 192'h99);
        check_eq("n1_busy", 192'(busy1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
